// File: rtl/add_sub_acc.sv
// add_sub_acc: handshaked add/subtract accumulator.
// One operand is accepted in IDLE, applied to the accumulator in EXEC and the
// result is presented in HOLD until the downstream side accepts it.
// Subtraction is done as acc + ~operand + 1, so op doubles as the carry-in
// and cout reads as "no borrow" for subtracts.
module add_sub_acc #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] operand,
  input  logic             clear,
  output logic [WIDTH-1:0] acc,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic [WIDTH-1:0] operand_q;
  logic             op_q;
  logic [WIDTH-1:0] effOperand;
  logic [WIDTH:0]   sum;
  logic             ovfCalc;

  logic [WIDTH-1:0] acc_q;
  logic             cout_q;
  logic             ovf_q;
  logic [3:0]       opCount_q;

  // An operand is taken only on an edge where we advertise readiness.
  assign accept = in_valid && in_ready;

  // State register; reset drops any in-flight operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE waits for an accepted operand, EXEC always lasts
  // one cycle, HOLD waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = HOLD;
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; a pending clear or an active reset masks readiness.
  always_comb begin
    in_ready  = (state_q == IDLE) && !clear && !rst;
    out_valid = (state_q == HOLD);
  end

  // Capture the operation on the accept edge so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand_q <= '0;
      op_q      <= 1'b0;
    end else if (accept) begin
      operand_q <= operand;
      op_q      <= op;
    end
  end

  // Adder: invert the operand for subtract and feed op in as the carry.
  // Overflow is judged on the effective operands actually entering the adder.
  always_comb begin
    effOperand = op_q ? ~operand_q : operand_q;
    sum        = {1'b0, acc_q} + {1'b0, effOperand} + {{WIDTH{1'b0}}, op_q};
    ovfCalc    = (acc_q[WIDTH-1] == effOperand[WIDTH-1]) &&
                 (sum[WIDTH-1] != acc_q[WIDTH-1]);
  end

  // Accumulator, flags and operation counter: cleared on request while idle,
  // updated once per operation on the EXEC edge, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      opCount_q <= 4'd0;
    end else if (state_q == IDLE && clear) begin
      acc_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      opCount_q <= 4'd0;
    end else if (state_q == EXEC) begin
      acc_q     <= sum[WIDTH-1:0];
      cout_q    <= sum[WIDTH];
      ovf_q     <= ovfCalc;
      opCount_q <= opCount_q + 4'd1;
    end
  end

  assign acc      = acc_q;
  assign cout     = cout_q;
  assign ovf      = ovf_q;
  assign op_count = opCount_q;

endmodule

// File: tb/tb_add_sub_acc.sv
// tb_add_sub_acc: directed and randomized checks of add_sub_acc against an
// integer-arithmetic reference model of the accumulator.
module tb_add_sub_acc;

  localparam int W = 4;
  localparam int MOD = 1 << W;
  localparam int SMAX = (MOD / 2) - 1;
  localparam int SMIN = -(MOD / 2);

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] operand;
  logic         clear;
  logic [W-1:0] acc;
  logic         cout;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   op_count;

  int errorCount;
  int checkCount;

  int mAcc;
  int mCout;
  int mOvf;
  int mCount;

  add_sub_acc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .clear     (clear),
    .acc       (acc),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_count  (op_count)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count it and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int toSigned(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  // Reference model: plain integer add/subtract with range checks.
  task automatic modelApply(input logic o, input int v);
    int raw;
    int sRes;
    if (!o) begin
      raw   = mAcc + v;
      mCout = (raw >= MOD) ? 1 : 0;
      sRes  = toSigned(mAcc) + toSigned(v);
    end else begin
      raw   = mAcc - v;
      mCout = (mAcc >= v) ? 1 : 0;
      sRes  = toSigned(mAcc) - toSigned(v);
    end
    mOvf   = (sRes > SMAX || sRes < SMIN) ? 1 : 0;
    mAcc   = (raw + MOD) % MOD;
    mCount = (mCount + 1) % 16;
  endtask

  task automatic modelClear();
    mAcc   = 0;
    mCout  = 0;
    mOvf   = 0;
    mCount = 0;
  endtask

  task automatic checkResult(input string tag);
    checkOutput({tag, ".acc"}, acc, mAcc);
    checkOutput({tag, ".cout"}, cout, mCout);
    checkOutput({tag, ".ovf"}, ovf, mOvf);
    checkOutput({tag, ".opCount"}, op_count, mCount);
    checkOutput({tag, ".outValid"}, out_valid, 1);
  endtask

  // One full transaction with out_ready high; starts mid-cycle in IDLE.
  task automatic applyStimulus(input logic o, input logic [W-1:0] v, input string tag);
    in_valid = 1'b1;
    op       = o;
    operand  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 1'($urandom);
    operand  = W'($urandom);
    checkOutput({tag, ".execInReady"}, in_ready, 0);
    checkOutput({tag, ".execValid"}, out_valid, 0);
    @(posedge clk); #1;
    modelApply(o, int'(v));
    checkResult(tag);
    @(posedge clk); #1;
    checkOutput({tag, ".idleValid"}, out_valid, 0);
    checkOutput({tag, ".idleReady"}, in_ready, 1);
  endtask

  task automatic doClear();
    clear = 1'b1;
    #1;
    checkOutput("clearInReady", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    modelClear();
    checkOutput("clear.acc", acc, 0);
    checkOutput("clear.opCount", op_count, 0);
    checkOutput("clear.cout", cout, 0);
    checkOutput("clear.ovf", ovf, 0);
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    op         = 1'b0;
    operand    = '0;
    clear      = 1'b0;
    out_ready  = 1'b1;
    modelClear();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.acc", acc, 0);
    checkOutput("rst.outValid", out_valid, 0);
    checkOutput("rst.inReady", in_ready, 0);
    checkOutput("rst.opCount", op_count, 0);
    rst = 1'b0;
    #1;
    checkOutput("postRst.inReady", in_ready, 1);

    // Add sequence: 5 then 7 (signed overflow on the second).
    applyStimulus(1'b0, 4'd5, "add5");
    applyStimulus(1'b0, 4'd7, "add7");
    checkOutput("add7.accConst", acc, 12);
    checkOutput("add7.ovfConst", ovf, 1);

    // Subtract with borrow from 3.
    doClear();
    applyStimulus(1'b0, 4'd3, "load3");
    applyStimulus(1'b1, 4'd5, "sub5");
    checkOutput("sub5.accConst", acc, 14);
    checkOutput("sub5.coutConst", cout, 0);
    applyStimulus(1'b1, 4'd2, "sub2");
    checkOutput("sub2.coutConst", cout, 1);

    // Wrap 15 + 1.
    doClear();
    applyStimulus(1'b0, 4'd15, "load15");
    applyStimulus(1'b0, 4'd1, "wrap");
    checkOutput("wrap.accConst", acc, 0);
    checkOutput("wrap.coutConst", cout, 1);

    // Operation counter wraps after 16 operations from zero.
    doClear();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'($urandom), W'($urandom), "cntRun");
    end
    checkOutput("cntWrap", op_count, 0);

    // Backpressure: result held for 5 cycles; in_valid and clear ignored.
    in_valid = 1'b1;
    op       = 1'b0;
    operand  = 4'd3;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    modelApply(1'b0, 3);
    checkResult("bp");
    in_valid = 1'b1;
    operand  = 4'd5;
    clear    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("bp.holdValid", out_valid, 1);
      checkOutput("bp.holdAcc", acc, mAcc);
      checkOutput("bp.holdInReady", in_ready, 0);
      checkOutput("bp.holdCount", op_count, mCount);
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp.releaseValid", out_valid, 0);
    checkOutput("bp.releaseAcc", acc, mAcc);
    checkOutput("bp.releaseInReady", in_ready, 1);

    // Clear contention: clear beats a simultaneous operand.
    doClear();
    applyStimulus(1'b0, 4'd9, "load9");
    clear    = 1'b1;
    in_valid = 1'b1;
    op       = 1'b0;
    operand  = 4'd4;
    #1;
    checkOutput("cc.inReady", in_ready, 0);
    @(posedge clk); #1;
    modelClear();
    checkOutput("cc.acc", acc, 0);
    checkOutput("cc.opCount", op_count, 0);
    checkOutput("cc.notAccepted", out_valid, 0);
    clear = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("cc.execValid", out_valid, 0);
    @(posedge clk); #1;
    modelApply(1'b0, 4);
    checkResult("cc");
    checkOutput("cc.accConst", acc, 4);
    @(posedge clk); #1;

    // Randomized operations with occasional clears.
    for (int i = 0; i < 40; i++) begin
      if (($urandom % 8) == 0) begin
        doClear();
      end else begin
        applyStimulus(1'($urandom), W'($urandom), "rand");
      end
    end

    // Asynchronous reset in the middle of EXEC.
    applyStimulus(1'b0, 4'd2, "preRst");
    in_valid = 1'b1;
    op       = 1'b0;
    operand  = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst.acc", acc, 0);
    checkOutput("arst.outValid", out_valid, 0);
    checkOutput("arst.inReady", in_ready, 0);
    checkOutput("arst.opCount", op_count, 0);
    #1;
    rst = 1'b0;
    modelClear();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("arst.afterValid", out_valid, 0);
      checkOutput("arst.afterAcc", acc, 0);
    end
    checkOutput("arst.inReadyAfter", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
